// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-granular round-robin arbiter that shares one
// AXI4-Stream master among NUM_PORTS stream producers. A grant is held from
// the first beat of a packet until its tlast. Packets longer than MAX_BEATS
// are cut with a forced tlast, and the rest of the source packet is drained.
// The data path is purely combinational; only control state is registered.
module axis_rr_arbiter #(
  parameter int unsigned NUM_PORTS          = 4,
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned MAX_BEATS          = 256
) (
  input  logic                                      axis_aclk,
  input  logic                                      axis_areset,
  input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
  input  logic [NUM_PORTS*C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
  output logic [NUM_PORTS-1:0]                      s_axis_tready,
  output logic                                      m_axis_tvalid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]             m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]           m_axis_tstrb,
  output logic                                      m_axis_tlast,
  input  logic                                      m_axis_tready,
  output logic [$clog2(NUM_PORTS)-1:0]              grant_id,
  output logic                                      busy,
  output logic                                      error_trunc,
  output logic [15:0]                               pkt_count
);

  localparam int unsigned W  = C_AXIS_TDATA_WIDTH;
  localparam int unsigned SW = C_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned GW = $clog2(NUM_PORTS);
  localparam int unsigned CW = $clog2(MAX_BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [15:0]     pkt_count_q, pkt_count_d;
  logic            err_q, err_d;

  logic            src_valid;
  logic            src_last;
  logic            forced_last;
  logic            beat;
  logic [GW-1:0]   rr_winner;

  // Round-robin scan: offsets are visited from farthest to nearest so the
  // nearest valid port after `last` is the one that sticks.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                            input logic [GW-1:0]        last);
    logic [GW-1:0] win;
    int unsigned   idx;
    win = last;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = (32'(last) + (NUM_PORTS - k)) % NUM_PORTS;
      if (req[idx]) begin
        win = GW'(idx);
      end
    end
    return win;
  endfunction

  // Select the granted source and decide where the current packet ends.
  always_comb begin
    src_valid   = s_axis_tvalid[grant_q];
    src_last    = s_axis_tlast[grant_q];
    forced_last = (beat_cnt_q == LAST_BEAT);
    rr_winner   = rr_pick(s_axis_tvalid, last_grant_q);
  end

  // Zero-latency data path: mux the granted port onto the master and route
  // downstream ready back to that port only.
  always_comb begin
    m_axis_tvalid = (state_q == ST_XFER) && src_valid;
    m_axis_tdata  = s_axis_tdata[32'(grant_q)*W +: W];
    m_axis_tstrb  = s_axis_tstrb[32'(grant_q)*SW +: SW];
    m_axis_tlast  = (state_q == ST_XFER) && (src_last || forced_last);
    s_axis_tready = '0;
    if (state_q == ST_XFER) begin
      s_axis_tready[grant_q] = m_axis_tready;
    end else if (state_q == ST_DRAIN) begin
      s_axis_tready[grant_q] = 1'b1;
    end
    beat = m_axis_tvalid && m_axis_tready;
  end

  // Next-state logic for arbitration, beat counting and packet accounting.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    pkt_count_d  = pkt_count_q;
    err_d        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|s_axis_tvalid) begin
          grant_d    = rr_winner;
          beat_cnt_d = '0;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (beat) begin
          if (src_last) begin
            pkt_count_d  = pkt_count_q + 16'd1;
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end else if (forced_last) begin
            // Cut packet: the forced tlast closes it downstream, the source
            // keeps the grant until its own tlast has been swallowed.
            pkt_count_d = pkt_count_q + 16'd1;
            err_d       = 1'b1;
            state_d     = ST_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (src_valid && src_last) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state registers; reset leaves port 0 with first priority.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_PORTS - 1);
      beat_cnt_q   <= '0;
      pkt_count_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      pkt_count_q  <= pkt_count_d;
      err_q        <= err_d;
    end
  end

  assign grant_id    = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign error_trunc = err_q;
  assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (4 ports, 32-bit data,
// MAX_BEATS=4 so truncation is reachable with short packets).
module tb_axis_rr_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     s_tvalid;
  logic [NP*W-1:0]   s_tdata;
  logic [NP*W/8-1:0] s_tstrb;
  logic [NP-1:0]     s_tlast;
  logic [NP-1:0]     s_tready;
  logic              m_tvalid;
  logic [W-1:0]      m_tdata;
  logic [W/8-1:0]    m_tstrb;
  logic              m_tlast;
  logic              m_tready;
  logic [1:0]        grant_id;
  logic              busy;
  logic              err;
  logic [15:0]       pkt_count;

  int unsigned passes = 0;
  int unsigned total  = 0;

  axis_rr_arbiter #(
    .NUM_PORTS          (NP),
    .C_AXIS_TDATA_WIDTH (W),
    .MAX_BEATS          (4)
  ) dut (
    .axis_aclk     (clk),
    .axis_areset   (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .grant_id      (grant_id),
    .busy          (busy),
    .error_trunc   (err),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic src(input int p, input logic v, input logic [31:0] d, input logic l);
    s_tvalid[p]         = v;
    s_tdata[p*W +: W]   = d;
    s_tlast[p]          = l;
    s_tstrb[p*4 +: 4]   = 4'(p + 8);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] fdata(input int p, input int n, input int b);
    return 32'(32'hA000 + p * 256 + n * 16 + b);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt [NP];
    int p;
    int b;
    int c;
    logic rdy;

    rst      = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tlast  = '0;
    m_tready = 1'b0;

    // ---- reset state
    tick();
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_tready", 32'(s_tready), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pkt", 32'(pkt_count), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    tick();

    // ---- single port, 3-beat packet 1,2,3
    m_tready = 1'b1;
    src(0, 1'b1, 32'd1, 1'b0);
    settle();
    chk("sp_idle_tvalid", 32'(m_tvalid), 0);
    chk("sp_idle_tready", 32'(s_tready), 0);
    tick();
    settle();
    chk("sp_grant", 32'(grant_id), 0);
    chk("sp_busy", 32'(busy), 1);
    chk("sp_b0_tvalid", 32'(m_tvalid), 1);
    chk("sp_b0_data", m_tdata, 1);
    chk("sp_b0_strb", 32'(m_tstrb), 8);
    chk("sp_b0_last", 32'(m_tlast), 0);
    chk("sp_b0_tready", 32'(s_tready), 1);
    tick();
    src(0, 1'b1, 32'd2, 1'b0);
    settle();
    chk("sp_b1_data", m_tdata, 2);
    chk("sp_b1_last", 32'(m_tlast), 0);
    tick();
    src(0, 1'b1, 32'd3, 1'b1);
    settle();
    chk("sp_b2_data", m_tdata, 3);
    chk("sp_b2_last", 32'(m_tlast), 1);
    tick();
    src(0, 1'b0, 32'd0, 1'b0);
    settle();
    chk("sp_pkt", 32'(pkt_count), 1);
    chk("sp_err", 32'(err), 0);
    chk("sp_end_busy", 32'(busy), 0);
    chk("sp_end_tvalid", 32'(m_tvalid), 0);
    chk("sp_end_grant", 32'(grant_id), 0);

    // ---- fairness: all ports hold 2-beat packets, starting from reset
    rst = 1'b1;
    settle();
    rst = 1'b0;
    tick();
    for (int i = 0; i < NP; i++) begin
      cnt[i] = 0;
      src(i, 1'b1, fdata(i, 0, 0), 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      p = k % NP;
      settle();
      chk("fair_idle_tvalid", 32'(m_tvalid), 0);
      chk("fair_idle_busy", 32'(busy), 0);
      tick();
      settle();
      chk("fair_grant", 32'(grant_id), 32'(p));
      chk("fair_b0_tvalid", 32'(m_tvalid), 1);
      chk("fair_b0_data", m_tdata, fdata(p, cnt[p], 0));
      chk("fair_b0_strb", 32'(m_tstrb), 32'(p + 8));
      chk("fair_b0_last", 32'(m_tlast), 0);
      chk("fair_b0_tready", 32'(s_tready), 32'(1 << p));
      tick();
      src(p, 1'b1, fdata(p, cnt[p], 1), 1'b1);
      settle();
      chk("fair_b1_tvalid", 32'(m_tvalid), 1);
      chk("fair_b1_data", m_tdata, fdata(p, cnt[p], 1));
      chk("fair_b1_last", 32'(m_tlast), 1);
      tick();
      cnt[p]++;
      src(p, 1'b1, fdata(p, cnt[p], 0), 1'b0);
    end
    settle();
    chk("fair_pkt", 32'(pkt_count), 8);
    for (int i = 0; i < NP; i++) src(i, 1'b0, 32'd0, 1'b0);
    tick();

    // ---- backpressure: port 2, 4 beats 20..23, ready 1,0,0,1,...
    src(2, 1'b1, 32'd20, 1'b0);
    settle();
    tick();
    settle();
    chk("bp_grant", 32'(grant_id), 2);
    b = 0;
    c = 0;
    while (b < 4 && c < 20) begin
      rdy = (c % 4 == 0) || (c % 4 == 3);
      m_tready = rdy;
      src(2, 1'b1, 32'(20 + b), (b == 3));
      settle();
      chk("bp_tvalid", 32'(m_tvalid), 1);
      chk("bp_data", m_tdata, 32'(20 + b));
      chk("bp_last", 32'(m_tlast), 32'(b == 3));
      chk("bp_tready", 32'(s_tready), rdy ? 32'h4 : 32'h0);
      tick();
      if (rdy) b++;
      c++;
    end
    chk("bp_beats", 32'(b), 4);
    chk("bp_cycles", 32'(c), 8);
    src(2, 1'b0, 32'd0, 1'b0);
    m_tready = 1'b1;
    settle();
    chk("bp_pkt", 32'(pkt_count), 9);
    chk("bp_err", 32'(err), 0);
    chk("bp_busy", 32'(busy), 0);

    // ---- truncation: port 1 sends 10..15, port 3 one beat afterwards
    rst = 1'b1;
    settle();
    rst = 1'b0;
    tick();
    src(1, 1'b1, 32'd10, 1'b0);
    settle();
    tick();
    src(3, 1'b1, 32'd99, 1'b1);
    settle();
    chk("tr_grant", 32'(grant_id), 1);
    for (int i = 0; i < 4; i++) begin
      src(1, 1'b1, 32'(10 + i), 1'b0);
      settle();
      chk("tr_tvalid", 32'(m_tvalid), 1);
      chk("tr_data", m_tdata, 32'(10 + i));
      chk("tr_last", 32'(m_tlast), 32'(i == 3));
      chk("tr_tready", 32'(s_tready), 32'h2);
      chk("tr_err_low", 32'(err), 0);
      tick();
    end
    src(1, 1'b1, 32'd14, 1'b0);
    settle();
    chk("tr_err_pulse", 32'(err), 1);
    chk("tr_pkt_cut", 32'(pkt_count), 1);
    chk("tr_drain_tvalid", 32'(m_tvalid), 0);
    chk("tr_drain_tready", 32'(s_tready), 32'h2);
    chk("tr_drain_busy", 32'(busy), 1);
    chk("tr_drain_grant", 32'(grant_id), 1);
    tick();
    src(1, 1'b1, 32'd15, 1'b1);
    settle();
    chk("tr_err_once", 32'(err), 0);
    chk("tr_drain2_tvalid", 32'(m_tvalid), 0);
    chk("tr_drain2_tready", 32'(s_tready), 32'h2);
    tick();
    src(1, 1'b0, 32'd0, 1'b0);
    settle();
    chk("tr_idle_busy", 32'(busy), 0);
    chk("tr_idle_tready", 32'(s_tready), 0);
    tick();
    settle();
    chk("tr_p3_grant", 32'(grant_id), 3);
    chk("tr_p3_data", m_tdata, 99);
    chk("tr_p3_last", 32'(m_tlast), 1);
    chk("tr_p3_tready", 32'(s_tready), 32'h8);
    tick();
    src(3, 1'b0, 32'd0, 1'b0);
    settle();
    chk("tr_pkt", 32'(pkt_count), 2);
    chk("tr_end_err", 32'(err), 0);

    // ---- async reset in the middle of a 5-beat packet from port 2
    src(2, 1'b1, 32'd50, 1'b0);
    settle();
    tick();
    settle();
    chk("ar_grant", 32'(grant_id), 2);
    chk("ar_b0_data", m_tdata, 50);
    tick();
    src(2, 1'b1, 32'd51, 1'b0);
    settle();
    chk("ar_b1_tvalid", 32'(m_tvalid), 1);
    chk("ar_b1_tready", 32'(s_tready), 32'h4);
    rst = 1'b1;
    settle();
    chk("ar_tvalid", 32'(m_tvalid), 0);
    chk("ar_tready", 32'(s_tready), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_grant0", 32'(grant_id), 0);
    chk("ar_pkt", 32'(pkt_count), 0);
    src(0, 1'b1, 32'd70, 1'b1);
    src(1, 1'b1, 32'd71, 1'b1);
    src(2, 1'b1, 32'd72, 1'b1);
    rst = 1'b0;
    settle();
    chk("ar_idle_tvalid", 32'(m_tvalid), 0);
    tick();
    settle();
    chk("ar_prio_grant", 32'(grant_id), 0);
    chk("ar_prio_data", m_tdata, 70);
    chk("ar_prio_tready", 32'(s_tready), 32'h1);
    tick();
    settle();
    chk("ar_prio_pkt", 32'(pkt_count), 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
